// File: rtl/proj_fm_window_buf_if.sv
// Write/read handshake bundle for the multi-buffer genome window store.
// The master drives bytes and consumes windows. The slave is the buffer itself.
interface proj_fm_window_buf_if #(
  parameter int BUFFER_COUNT = 2,
  parameter int DEPTH        = 64,
  parameter int DATA_BITS    = 8,
  parameter int WINDOW       = 8,
  parameter int MAX_STRIDE   = 8
) ();
  localparam int PW = $clog2(BUFFER_COUNT * DEPTH);
  localparam int SW = $clog2(MAX_STRIDE + 1);

  logic                        in_wvalid;
  logic                        out_wready;
  logic [DATA_BITS-1:0]        in_wdata;
  logic [SW-1:0]               in_stride;
  logic                        out_rvalid;
  logic                        in_rready;
  logic [WINDOW*DATA_BITS-1:0] out_rdata;
  logic [PW-1:0]               out_rpos;
  logic [31:0]                 out_win_count;

  modport master (
    output in_wvalid, in_wdata, in_stride, in_rready,
    input  out_wready, out_rvalid, out_rdata, out_rpos, out_win_count
  );

  modport slave (
    input  in_wvalid, in_wdata, in_stride, in_rready,
    output out_wready, out_rvalid, out_rdata, out_rpos, out_win_count
  );
endinterface

// File: rtl/proj_fm_window_buf.sv
// Circular multi-buffer byte store. It emits WINDOW-byte windows at a runtime stride.
// A buffer returns to the writer once the read pointer has moved past it.
module proj_fm_window_buf #(
  parameter int BUFFER_COUNT = 2,
  parameter int DEPTH        = 64,
  parameter int DATA_BITS    = 8,
  parameter int WINDOW       = 8,
  parameter int MAX_STRIDE   = 8
) (
  input logic                   in_clk,
  input logic                   in_rst_n,
  input logic                   in_flush,
  proj_fm_window_buf_if.slave   bus
);
  localparam int TOTAL = BUFFER_COUNT * DEPTH;
  localparam int PW    = $clog2(TOTAL);
  localparam int BW    = $clog2(BUFFER_COUNT);
  localparam int SW    = $clog2(MAX_STRIDE + 1);
  localparam int RW    = WINDOW * DATA_BITS;

  logic [DATA_BITS-1:0]    mem [TOTAL];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_next;
  logic [PW-1:0]           rd_next;
  logic [PW-1:0]           win_end;
  logic [PW-1:0]           step;
  logic [BUFFER_COUNT-1:0] full;
  logic [BUFFER_COUNT-1:0] full_next;
  logic                    accept;
  logic                    avail;
  logic                    load;
  logic                    drop;
  logic [RW-1:0]           window;
  logic                    rvalid_q;
  logic [RW-1:0]           rdata_q;
  logic [PW-1:0]           rpos_q;
  logic [31:0]             win_count_q;

  // TOTAL is a power of two, so the top BW bits of a pointer select its buffer.
  function automatic logic [BW-1:0] buf_of(input logic [PW-1:0] p);
    return p[PW-1 -: BW];
  endfunction

  assign bus.out_wready    = !full[buf_of(wr_ptr)];
  assign bus.out_rvalid    = rvalid_q;
  assign bus.out_rdata     = rdata_q;
  assign bus.out_rpos      = rpos_q;
  assign bus.out_win_count = win_count_q;

  always_comb begin
    step    = (bus.in_stride == SW'(0)) ? PW'(1) : PW'(bus.in_stride);
    wr_next = wr_ptr + PW'(1);
    rd_next = rd_ptr + step;
    win_end = rd_ptr + PW'(WINDOW - 1);
    accept  = bus.in_wvalid && bus.out_wready;
    avail   = full[buf_of(rd_ptr)] && full[buf_of(win_end)];
    load    = avail && (!rvalid_q || bus.in_rready);
    drop    = bus.in_rready && rvalid_q && !avail;
  end

  // Completion and release can never target the same buffer on one edge.
  always_comb begin
    full_next = full;
    if (accept && (buf_of(wr_next) != buf_of(wr_ptr))) begin
      full_next[buf_of(wr_ptr)] = 1'b1;
    end
    if (load && (buf_of(rd_next) != buf_of(rd_ptr))) begin
      full_next[buf_of(rd_ptr)] = 1'b0;
    end
  end

  always_comb begin
    window = '0;
    for (int i = 0; i < WINDOW; i++) begin
      window[i*DATA_BITS +: DATA_BITS] = mem[rd_ptr + PW'(i)];
    end
  end

  always_ff @(posedge in_clk) begin
    if (accept && !in_flush) begin
      mem[wr_ptr] <= bus.in_wdata;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= '0;
    end else if (in_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= '0;
    end else begin
      full <= full_next;
      if (accept) begin
        wr_ptr <= wr_next;
      end
      if (load) begin
        rd_ptr <= rd_next;
      end
    end
  end

  // The output register only changes on a load or on an idle drop of valid.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rpos_q      <= '0;
      win_count_q <= '0;
    end else if (in_flush) begin
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rpos_q      <= '0;
      win_count_q <= '0;
    end else if (load) begin
      rvalid_q    <= 1'b1;
      rdata_q     <= window;
      rpos_q      <= rd_ptr;
      win_count_q <= win_count_q + 32'd1;
    end else if (drop) begin
      rvalid_q    <= 1'b0;
    end
  end
endmodule

// File: doc/proj_fm_window_buf.md
Name: proj_fm_window_buf

Overview:
- Parametrised multi-buffer genome byte store feeding the Minhash k-mer extender; successor to the fixed FM RAM.
- Bytes stream in through a valid/ready write port and fill BUFFER_COUNT buffers of DEPTH bytes each, treated as one circular byte space.
- A valid/ready read port emits WINDOW-byte windows at a runtime-selectable stride. Windows may straddle a buffer boundary, including the wrap from the last buffer to buffer 0.
- Buffers are released to the writer as the read pointer passes them.

Parameters:
BUFFER_COUNT, 2, number of buffers (power of 2, >=2)
DEPTH, 64, bytes per buffer (power of 2)
DATA_BITS, 8, bits per genome byte
WINDOW, 8, bytes per emitted window (1..DEPTH)
MAX_STRIDE, 8, largest read advance (1..DEPTH)

Ports:
in_clk  input  1  clock
in_rst_n  input  1  asynchronous active-low reset
in_flush  input  1  synchronous clear of all pointers/state
in_wvalid  input  1  write byte valid
out_wready  output  1  write byte accepted when high with in_wvalid
in_wdata  input  DATA_BITS  write byte
in_stride  input  $clog2(MAX_STRIDE+1)  read advance, sampled at load
out_rvalid  output  1  window valid
in_rready  input  1  window consumed
out_rdata  output  WINDOW*DATA_BITS  window; byte at out_rpos in bits [DATA_BITS-1:0]
out_rpos  output  $clog2(BUFFER_COUNT*DEPTH)  start position of window, mod TOTAL
out_win_count  output  32  windows loaded since reset/flush, wraps

Behaviour:
- TOTAL = BUFFER_COUNT*DEPTH. Pointers wr_ptr and rd_ptr run mod TOTAL. Buffer of pointer p = p / DEPTH.
- Per-buffer registered flag full[b].
- Reset (async) and in_flush (sync, highest priority over all events): wr_ptr=0, rd_ptr=0, all full=0, out_rvalid=0, out_rdata=0, out_rpos=0, out_win_count=0. Memory contents are not cleared.
- Write port:
  - out_wready = !full[wr_ptr/DEPTH] (combinational); it is 1 after reset.
  - Accept = in_wvalid && out_wready: mem[wr_ptr] <= in_wdata, wr_ptr++.
  - If the accepted byte is the last byte of its buffer, that buffer's full is set.
- Window availability (combinational from registered state):
  - avail = full[rd_ptr/DEPTH] && full[((rd_ptr+WINDOW-1) mod TOTAL)/DEPTH].
  - A buffer completed at edge k makes windows available from cycle k+1.
- Load event L = avail && (!out_rvalid || in_rready). On L:
  - out_rdata <= mem[rd_ptr .. rd_ptr+WINDOW-1 mod TOTAL]
  - out_rpos <= rd_ptr
  - out_rvalid <= 1
  - out_win_count++
  - rd_ptr += s, where s = in_stride, and in_stride==0 is treated as 1. Values above MAX_STRIDE are undefined.
- Release: on L, if (rd_ptr+s)/DEPTH differs from rd_ptr/DEPTH, clear full of the old buffer. out_wready for that buffer rises the next cycle.
- in_rready && out_rvalid && !avail -> out_rvalid <= 0.
- Output register holds stable while out_rvalid && !in_rready (no drop, no change).
- Throughput: one window per cycle while avail and the consumer is ready.
- Write completion and read release on the same edge act on different buffers; both take effect.

Test Plan:
- BUFFER_COUNT=2, DEPTH=64, WINDOW=8, stride 1, in_rready=1; write bytes 00..3F back-to-back -> out_rvalid rises the cycle after the load following the byte-3F write. First out_rdata=3F3E..? no: bytes 07..00 (0x0706050403020100), out_rpos=0. Exactly 57 windows (pos 0..56), then stall; out_win_count=57.
- Continue by writing 40..7F -> window at pos 60 = bytes 43..3C. The load that moves rd_ptr from 63 to 64 clears full[0]; out_wready returns to 1 the next cycle.
- Write 128 bytes with in_rready=0 -> out_wready=0 after byte 7F is accepted; byte 0x80 is held on in_wdata until release; out_rdata is frozen at pos 0.
- Steady state over wrap: window at pos 124 = bytes {mem[3..0], mem[127..124]}, emitted only when both buffers are full; out_rpos then wraps to 0..3.
- Stride 8 -> out_rpos 0,8,16,..,56. Stride 0 -> behaves as stride 1.
- Assert in_rst_n=0 asynchronously mid-stream (and separately in_flush=1 for one cycle) -> all outputs zero, out_wready=1. The next write lands at position 0.
